seg7_disp_mux: RTL and testbench
================================

// Module: seg7_disp_mux
// PURPOSE
//   Time-multiplexed driver for a 4-digit common-anode 7-segment display.
//   Consumes the four 8421 BCD digits from the binary-to-BCD converter
//   (bcd3 = MSB ... bcd0 = LSB), which updates the score/time value.
//   Double-buffers the digits so a new value appears only at a frame boundary
//   (no tearing). Scans one digit per refresh tick and drives the board
//   anode/segment pins.
// PARAMETERS
//   REFRESH_DIV  100000  clk cycles per digit slot (100 MHz -> 1 kHz/digit); must be >= 2
//   CNT_W        17      prescaler width; 2**CNT_W > REFRESH_DIV-1
// PORTS
//   clk       in   1  system clock, all logic on rising edge
//   rst       in   1  synchronous reset, active-high
//   bcd0      in   4  LSB BCD digit (units)
//   bcd1      in   4  BCD digit (tens)
//   bcd2      in   4  BCD digit (hundreds)
//   bcd3      in   4  MSB BCD digit (thousands)
//   bcd_load  in   1  1-cycle strobe: sample bcd3..bcd0 into staging register
//   dp_mask   in   4  decimal point enable per digit, bit n = digit n, 1 = lit
//   an        out  4  digit anodes, active-low, one-hot-low while scanning
//   seg       out  7  segments {g,f,e,d,c,b,a}, active-low
//   dp        out  1  decimal point, active-low
// BEHAVIOUR
//   - Reset (sync, has priority over all else): an=4'b1111, seg=7'h7F, dp=1,
//     prescaler=0, digit index idx=0, staging=0, shadow=0, pending=0.
//   - Prescaler counts 0..REFRESH_DIV-1, then wraps to 0. tick=1 in the cycle the
//     prescaler holds REFRESH_DIV-1. On tick: idx <= idx+1 (mod 4, 3 -> 0).
//   - Frame boundary = tick while idx==3.
//   - bcd_load: staging <= {bcd3..bcd0} and pending <= 1. A later load before the
//     boundary overwrites staging (last value wins).
//   - At the frame boundary with pending=1: shadow <= staging and pending <= 0.
//     With bcd_load in the same cycle, shadow <= the live bcd inputs directly.
//     pending then ends at 0. bcd_load without pending at the boundary behaves
//     the same way.
//   - Outputs are registered from (idx, shadow, dp_mask), giving 1 clk latency
//     after an idx/shadow change:
//       an  = ~(4'b0001 << idx)
//       seg = decode(shadow[idx])
//       dp  = ~dp_mask[idx]
//   - First lit digit: 1 clk after reset release, idx=0 -> an=4'b1110, seg shows '0'.
//   - Decoder (active-low gfedcba): 0=7'h40 1=7'h79 2=7'h24 3=7'h30 4=7'h19
//     5=7'h12 6=7'h02 7=7'h78 8=7'h00 9=7'h10. Non-BCD 10..15 -> '-' = 7'h3F.
//   - dp_mask is not buffered; it is sampled live every cycle.
//   - Reset mid-frame: scan restarts at idx=0 and shadow is cleared. Any
//     pending load is discarded.
// CONFIGURATION
//   DISP_LZB_EN defined: leading-zero blanking on shadow contents.
//     - Digit 3 is blanked if it is 0.
//     - Digit 2 is blanked if digits 3 and 2 are both 0.
//     - Digit 1 is blanked if digits 3, 2 and 1 are all 0.
//     - Digit 0 is never blanked.
//     - In a blanked slot: an=4'b1111, seg=7'h7F, dp=1. Slot timing is unchanged.
//   DISP_LZB_EN undefined: all four digits are always shown, leading zeros included.
// TESTING (bench uses REFRESH_DIV=4)
//   1. Hold rst for 3 clk -> an=4'b1111, seg=7'h7F, dp=1 throughout. After release,
//      an steps 1110,1101,1011,0111 every 4 clk, seg=7'h40.
//   2. Load 1,2,3,4 (bcd3..0) with bcd_load mid-frame -> old digits kept until
//      idx 3->0. Next frame: an=1110 seg=7'h19, an=1101 seg=7'h30,
//      an=1011 seg=7'h24, an=0111 seg=7'h79.
//   3. Two loads in one frame (1111, then 9876) -> only 9,8,7,6 is ever displayed.
//      Load coincident with the boundary -> value is displayed in the very next frame.
//   4. bcd0=4'hA, bcd1=4'hF loaded -> digit 0 and digit 1 slots show seg=7'h3F.
//      dp_mask=4'b0100 -> dp=0 only while an=1011.
//   5. With DISP_LZB_EN, load 0,0,4,2 -> digits 3 and 2 have an=1111.
//      Load 0000 -> only digit 0 is lit, showing 7'h40.
//      Without the macro, all four digits are lit.
//   6. Assert rst while idx=2 with a load pending -> next cycle outputs are at
//      reset values, scan restarts at idx=0, and shadow=0000 is displayed.

Source files
------------

// File: rtl/seg7_disp_mux.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_disp_mux
//  Purpose  : Time-multiplexed driver for a 4-digit common-anode 7-segment
//             display. Digits are double-buffered (staging -> shadow) so a
//             new value only takes effect at a frame boundary. Each refresh
//             tick scans to the next digit. The anode, segment and dp pins
//             are all registered.
//  Options  : DISP_LZB_EN - when defined, leading zeros in the shadow value
//             are blanked. Digit 0 is never blanked.
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_disp_mux #(
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] bcd0,
    input  logic [3:0] bcd1,
    input  logic [3:0] bcd2,
    input  logic [3:0] bcd3,
    input  logic       bcd_load,
    input  logic [3:0] dp_mask,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam logic [CNT_W-1:0] c_PRESC_MAX = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] r_presc;
    logic [1:0]       r_idx;
    logic [15:0]      r_staging;
    logic [15:0]      r_shadow;
    logic             r_pending;

    logic             w_tick;
    logic             w_frame_end;
    logic [15:0]      w_live;
    logic [3:0]       w_digit;
    logic             w_blank;

    // Active-low gfedcba patterns. Any non-BCD code is shown as a dash.
    function automatic logic [6:0] f_decode(input logic [3:0] d);
        logic [6:0] v;
        case (d)
            4'd0:    v = 7'h40;
            4'd1:    v = 7'h79;
            4'd2:    v = 7'h24;
            4'd3:    v = 7'h30;
            4'd4:    v = 7'h19;
            4'd5:    v = 7'h12;
            4'd6:    v = 7'h02;
            4'd7:    v = 7'h78;
            4'd8:    v = 7'h00;
            4'd9:    v = 7'h10;
            default: v = 7'h3F;
        endcase
        return v;
    endfunction

    assign w_tick      = (r_presc == c_PRESC_MAX);
    assign w_frame_end = w_tick && (r_idx == 2'd3);
    assign w_live      = {bcd3, bcd2, bcd1, bcd0};

    // Prescaler and digit scan index. A tick advances to the next slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_idx   <= 2'd0;
        end else if (w_tick) begin
            r_presc <= '0;
            r_idx   <= r_idx + 2'd1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Double buffer. A load coincident with the frame boundary bypasses
    // staging so that the value appears in the very next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_staging <= '0;
            r_shadow  <= '0;
            r_pending <= 1'b0;
        end else begin
            if (bcd_load) begin
                r_staging <= w_live;
            end
            if (w_frame_end) begin
                if (bcd_load) begin
                    r_shadow <= w_live;
                end else if (r_pending) begin
                    r_shadow <= r_staging;
                end
                r_pending <= 1'b0;
            end else if (bcd_load) begin
                r_pending <= 1'b1;
            end
        end
    end

    // Select the shadow digit for the current slot.
    always_comb begin
        w_digit = r_shadow[3:0];
        case (r_idx)
            2'd0:    w_digit = r_shadow[3:0];
            2'd1:    w_digit = r_shadow[7:4];
            2'd2:    w_digit = r_shadow[11:8];
            default: w_digit = r_shadow[15:12];
        endcase
    end

`ifdef DISP_LZB_EN
    logic w_blank3;
    logic w_blank2;
    logic w_blank1;

    assign w_blank3 = (r_shadow[15:12] == 4'd0);
    assign w_blank2 = w_blank3 && (r_shadow[11:8] == 4'd0);
    assign w_blank1 = w_blank2 && (r_shadow[7:4] == 4'd0);

    // Blank a slot when its digit and all more-significant digits are zero.
    always_comb begin
        w_blank = 1'b0;
        case (r_idx)
            2'd1:    w_blank = w_blank1;
            2'd2:    w_blank = w_blank2;
            2'd3:    w_blank = w_blank3;
            default: w_blank = 1'b0;
        endcase
    end
`else
    assign w_blank = 1'b0;
`endif

    // Registered pin drivers. They lag idx/shadow by one clock.
    always_ff @(posedge clk) begin
        if (rst || w_blank) begin
            an  <= 4'b1111;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= ~(4'b0001 << r_idx);
            seg <= f_decode(w_digit);
            dp  <= ~dp_mask[r_idx];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_disp_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_disp_mux
//  Purpose  : Self-checking bench for seg7_disp_mux with REFRESH_DIV=4.
//             Directed scenarios are followed by randomized traffic. Every
//             output is compared each cycle against a cycle-count based
//             reference model. Define DISP_LZB_EN for both bench and RTL to
//             check leading-zero blanking.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_disp_mux;

    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV;

    logic       clk;
    logic       rst;
    logic [3:0] bcd0, bcd1, bcd2, bcd3;
    logic       bcd_load;
    logic [3:0] dp_mask;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    int         cyc;
    logic [3:0] m_sh   [4];
    logic [3:0] m_stage[4];
    bit         m_pend;
    logic [6:0] dec_tab[16];
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;

    seg7_disp_mux #(.REFRESH_DIV(DIV), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .bcd0(bcd0), .bcd1(bcd1), .bcd2(bcd2), .bcd3(bcd3),
        .bcd_load(bcd_load), .dp_mask(dp_mask),
        .an(an), .seg(seg), .dp(dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit is_blank(int n);
`ifdef DISP_LZB_EN
        if (n == 0) return 1'b0;
        for (int k = n; k < 4; k++)
            if (m_sh[k] != 4'd0) return 1'b0;
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Advance the model by one rising edge, using the inputs as they stand.
    task automatic model_edge();
        int slot;
        if (rst) begin
            cyc = 0; m_pend = 1'b0;
            for (int k = 0; k < 4; k++) begin m_sh[k] = 4'd0; m_stage[k] = 4'd0; end
            e_an = 4'b1111; e_seg = 7'h7F; e_dp = 1'b1;
        end else begin
            slot = (cyc / DIV) % 4;
            if (is_blank(slot)) begin
                e_an = 4'b1111; e_seg = 7'h7F; e_dp = 1'b1;
            end else begin
                e_an  = 4'b1111;
                e_an[slot] = 1'b0;
                e_seg = dec_tab[m_sh[slot]];
                e_dp  = ~dp_mask[slot];
            end
            if (bcd_load) begin
                m_stage[0] = bcd0; m_stage[1] = bcd1; m_stage[2] = bcd2; m_stage[3] = bcd3;
                m_pend = 1'b1;
            end
            if (cyc % FRAME == FRAME - 1) begin
                if (m_pend) m_sh = m_stage;
                m_pend = 1'b0;
            end
            cyc++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        checks++;
        assert (an === e_an) else begin
            failures++; $error("FAIL an cyc=%0d observed=%b expected=%b", cyc, an, e_an);
        end
        checks++;
        assert (seg === e_seg) else begin
            failures++; $error("FAIL seg cyc=%0d observed=%h expected=%h", cyc, seg, e_seg);
        end
        checks++;
        assert (dp === e_dp) else begin
            failures++; $error("FAIL dp cyc=%0d observed=%b expected=%b", cyc, dp, e_dp);
        end
        bcd_load = 1'b0;
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_bcd(logic [3:0] d3, logic [3:0] d2, logic [3:0] d1, logic [3:0] d0);
        bcd3 = d3; bcd2 = d2; bcd1 = d1; bcd0 = d0;
    endtask

    // Run until the next edge is the given position within the frame.
    task automatic run_to(int pos);
        for (int i = 0; i < 2 * FRAME && (cyc % FRAME) != pos; i++) step();
    endtask

    initial begin
        dec_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
        cyc = 0; m_pend = 1'b0;
        rst = 1'b1; bcd_load = 1'b0; dp_mask = 4'b0000;
        set_bcd(4'd0, 4'd0, 4'd0, 4'd0);

        // 1: reset held for three clocks, then a full scan of zeros.
        steps(3);
        rst = 1'b0;
        steps(2 * FRAME);

        // 2: mid-frame load of 1,2,3,4.
        run_to(6);
        set_bcd(4'd1, 4'd2, 4'd3, 4'd4); bcd_load = 1'b1;
        steps(2 * FRAME);

        // 3: two loads in one frame, then a load on the boundary edge.
        run_to(2);
        set_bcd(4'd1, 4'd1, 4'd1, 4'd1); bcd_load = 1'b1; step();
        steps(3);
        set_bcd(4'd9, 4'd8, 4'd7, 4'd6); bcd_load = 1'b1;
        steps(2 * FRAME);
        run_to(FRAME - 1);
        set_bcd(4'd5, 4'd0, 4'd3, 4'd8); bcd_load = 1'b1;
        steps(FRAME + 2);

        // 4: non-BCD digits and a single decimal point.
        set_bcd(4'd2, 4'd7, 4'hF, 4'hA); bcd_load = 1'b1; dp_mask = 4'b0100;
        steps(3 * FRAME);

        // 5: leading zeros.
        dp_mask = 4'b1111;
        set_bcd(4'd0, 4'd0, 4'd4, 4'd2); bcd_load = 1'b1;
        steps(3 * FRAME);
        set_bcd(4'd0, 4'd0, 4'd0, 4'd0); bcd_load = 1'b1;
        steps(3 * FRAME);
        set_bcd(4'd0, 4'd3, 4'd0, 4'd0); bcd_load = 1'b1;
        steps(3 * FRAME);

        // 6: reset at idx 2 with a load pending.
        set_bcd(4'd7, 4'd7, 4'd7, 4'd7); bcd_load = 1'b1; step();
        run_to(2 * DIV + 1);
        rst = 1'b1; step();
        rst = 1'b0;
        steps(2 * FRAME);

        // Randomized traffic, with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            bcd0 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            bcd1 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            bcd2 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            bcd3 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            bcd_load = ($urandom_range(0, 9) == 0);
            dp_mask  = 4'($urandom_range(0, 15));
            rst      = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
